mem_arbiter: RTL

Two-master arbiter for the single-ported system RAM. Accepts the CPU load/store port and the DMA controller's memory port (`mem_request`/`mem_grant`/`mem_addr`/`mem_wdata`/`mem_wr_enable`/`mem_rd_enable`) and drives one RAM port. It is the block that generates the DMA controller's `mem_grant`. The arbiter is round-robin, with a hold-limit counter that forces a handover so neither master starves the other.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arb_hold_cnt.sv | 44 ++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package mem_arb_pkg;

  // Arbiter ownership states; every ownership change passes through IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } arb_state_e;

  // Identity of a master, as remembered in last_owner.
  typedef logic owner_t;

  localparam owner_t OWNER_CPU = 1'b0;
  localparam owner_t OWNER_DMA = 1'b1;

  // The master that is not the given one; used to break ties after a handover.
  function automatic owner_t other_owner(input owner_t owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, the DMA port and the shared RAM port.
// The arbiter takes the slave view; the masters and the RAM take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // CPU load/store port
  logic              cpu_req;
  logic              cpu_grant;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_wr_en;
  logic              cpu_rd_en;
  logic [DATA_W-1:0] cpu_rdata;

  // DMA controller memory port (mem_request / mem_grant / ...)
  logic              dma_req;
  logic              dma_grant;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_wr_en;
  logic              dma_rd_en;
  logic [DATA_W-1:0] dma_rdata;

  // Single RAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en,
    output cpu_grant, cpu_rdata,
    input  dma_req, dma_addr, dma_wdata, dma_wr_en, dma_rd_en,
    output dma_grant, dma_rdata,
    output ram_addr, ram_wdata, ram_we, ram_re,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wr_en, cpu_rd_en,
    input  cpu_grant, cpu_rdata,
    output dma_req, dma_addr, dma_wdata, dma_wr_en, dma_rd_en,
    input  dma_grant, dma_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_re,
    output ram_rdata
  );

endinterface

// File: rtl/mem_arb_hold_cnt.sv
// Saturating hold counter: counts owned cycles during which the other master
// is waiting, and flags when the owner has used up its allowance.
module mem_arb_hold_cnt
  import mem_arb_pkg::*;
#(
  parameter int  MAX_HOLD = 16,
  localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic clk,
  input  logic reset,   // asynchronous, active-low
  input  logic clr,
  input  logic en,
  output logic limit
);

  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, then increment until the limit, then hold.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (that would infer a latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit = (cnt_q == LIMIT_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the CPU and the DMA controller for the single
// RAM port, with a hold limit that forces a handover when the other master
// has waited MAX_HOLD owned cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active-low
  mem_arbiter_if.slave  bus
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_t     last_owner_q;
  owner_t     last_owner_d;

  logic hold_clr;
  logic hold_en;
  logic hold_limit;

  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              ram_we_c;
  logic              ram_re_c;

  // The counter only runs while someone owns the RAM and the other side waits.
  assign hold_clr = (state_q == IDLE);
  assign hold_en  = ((state_q == OWN_CPU) && bus.dma_req) ||
                    ((state_q == OWN_DMA) && bus.cpu_req);

  mem_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hold_clr),
    .en    (hold_en),
    .limit (hold_limit)
  );

  // Next-state: pick a new owner from IDLE, release on request drop or hold limit.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req && bus.dma_req) begin
          // Tie goes to whoever did not own last; after a forced release this
          // is always the waiting master.
          state_d = (other_owner(last_owner_q) == OWNER_CPU) ? OWN_CPU : OWN_DMA;
        end else if (bus.cpu_req) begin
          state_d = OWN_CPU;
        end else if (bus.dma_req) begin
          state_d = OWN_DMA;
        end
      end
      OWN_CPU: begin
        if (!bus.cpu_req || hold_limit) begin
          state_d = IDLE;
        end
      end
      OWN_DMA: begin
        if (!bus.dma_req || hold_limit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Remember the owner on every entry into an ownership state.
    if ((state_q == IDLE) && (state_d == OWN_CPU)) begin
      last_owner_d = OWNER_CPU;
    end else if ((state_q == IDLE) && (state_d == OWN_DMA)) begin
      last_owner_d = OWNER_DMA;
    end
  end

  // State and last-owner registers; DMA counts as last owner so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_DMA;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // RAM port mux: only the owner's address, data and strobes reach the RAM.
  always_comb begin
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    unique case (state_q)
      OWN_CPU: begin
        ram_addr_c  = bus.cpu_addr;
        ram_wdata_c = bus.cpu_wdata;
        ram_we_c    = bus.cpu_wr_en;
        ram_re_c    = bus.cpu_rd_en;
      end
      OWN_DMA: begin
        ram_addr_c  = bus.dma_addr;
        ram_wdata_c = bus.dma_wdata;
        ram_we_c    = bus.dma_wr_en;
        ram_re_c    = bus.dma_rd_en;
      end
      default: begin
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;
      end
    endcase
  end

  // Grants decode directly from the state register, so an asynchronous reset drops them at once.
  assign bus.cpu_grant = (state_q == OWN_CPU);
  assign bus.dma_grant = (state_q == OWN_DMA);

  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_re    = ram_re_c;

  // Read data goes to both masters unmodified; each qualifies it with its own grant.
  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.dma_rdata = bus.ram_rdata;

endmodule
